// File: rtl/tdc_trace_recorder.sv
// tdc_trace_recorder: encodes the TDC thermometer word to a depth code,
// sums 2^g_AVG_LOG2 codes per entry, records g_DEPTH entries after an armed
// trigger edge and drains them over a valid/ready stream.
// Build option: define TDC_BUBBLE_FILTER_EN to count contiguous ones from
// bit 0 instead of taking the popcount.
module tdc_trace_recorder #(
    parameter int g_LEN      = 32,
    parameter int g_DEPTH    = 256,
    parameter int g_AVG_LOG2 = 2,
    localparam int CW        = $clog2(g_LEN + 1),
    localparam int W         = CW + g_AVG_LOG2
) (
    input  logic             clkSample,
    input  logic             rst,
    input  logic [g_LEN-1:0] clkProp,
    input  logic             trig,
    input  logic             arm,
    output logic             busy,
    output logic             done,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [W-1:0]     rd_data,
    output logic             rd_last
);

    localparam int PW = $clog2(g_DEPTH);
    localparam int GW = (g_AVG_LOG2 > 0) ? g_AVG_LOG2 : 1;
    localparam logic [GW-1:0] GRP_LAST = GW'((1 << g_AVG_LOG2) - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(g_DEPTH - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] READOUT = 2'd3;

    logic [1:0]       state;
    logic [g_LEN-1:0] s0;
    logic [CW-1:0]    code;
    logic [CW-1:0]    s1;
    logic             t_meta, t_sync, t_prev, trig_rise;
    logic [W-1:0]     acc;
    logic [W-1:0]     sum;
    logic [GW-1:0]    grp;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    raddr;
    logic             cap_we;
    logic             rd_fire;
    logic [W-1:0]     ram_q;
    logic [W-1:0]     mem [g_DEPTH];

    // Depth encoder on the S0 word
    always_comb begin
        code = '0;
`ifdef TDC_BUBBLE_FILTER_EN
        // Lowest zero wins; scanning downward leaves the lowest index last.
        code = CW'(g_LEN);
        for (int i = g_LEN - 1; i >= 0; i--) begin
            if (!s0[i]) code = CW'(i);
        end
`else
        for (int i = 0; i < g_LEN; i++) begin
            code = code + CW'(s0[i]);
        end
`endif
    end

    // Two-stage input pipeline: raw sample, then encoded code
    always_ff @(posedge clkSample) begin
        if (rst) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= clkProp;
            s1 <= code;
        end
    end

    // Trigger synchronizer and registered rising-edge pulse
    always_ff @(posedge clkSample) begin
        if (rst) begin
            t_meta    <= 1'b0;
            t_sync    <= 1'b0;
            t_prev    <= 1'b0;
            trig_rise <= 1'b0;
        end else begin
            t_meta    <= trig;
            t_sync    <= t_meta;
            t_prev    <= t_sync;
            trig_rise <= t_sync & ~t_prev;
        end
    end

    assign cap_we  = (state == CAPTURE) && (grp == GRP_LAST);
    assign sum     = (grp == '0) ? W'(s1) : acc + W'(s1);
    assign rd_fire = rd_valid && rd_ready;

    // Control FSM with registered busy/done decodes
    always_ff @(posedge clkSample) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state == ARMED) || (state == CAPTURE);
            done <= (state == READOUT);
            case (state)
                IDLE:    if (arm) state <= ARMED;
                ARMED:   if (trig_rise) state <= CAPTURE;
                CAPTURE: if (cap_we && wr_ptr == PTR_LAST) state <= READOUT;
                READOUT: if (rd_fire && rd_ptr == PTR_LAST) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Group accumulator and write pointer during capture
    always_ff @(posedge clkSample) begin
        if (rst) begin
            acc    <= '0;
            grp    <= '0;
            wr_ptr <= '0;
        end else if (state == CAPTURE) begin
            acc <= sum;
            grp <= (grp == GRP_LAST) ? '0 : grp + 1'b1;
            if (cap_we) wr_ptr <= wr_ptr + 1'b1;
        end else if (state == IDLE && arm) begin
            acc    <= '0;
            grp    <= '0;
            wr_ptr <= '0;
        end
    end

    // Trace RAM write port (contents survive reset)
    always_ff @(posedge clkSample) begin
        if (cap_we) mem[wr_ptr] <= sum;
    end

    // Read port prefetches the next entry on acceptance so ram_q tracks rd_ptr
    assign raddr = rd_fire ? rd_ptr + 1'b1 : rd_ptr;
    always_ff @(posedge clkSample) begin
        ram_q <= mem[raddr];
    end

    // Readout handshake; valid waits one cycle for the first RAM read
    always_ff @(posedge clkSample) begin
        if (rst) begin
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else if (state == READOUT) begin
            if (!rd_valid) begin
                rd_valid <= 1'b1;
            end else if (rd_ready) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (rd_ptr == PTR_LAST) rd_valid <= 1'b0;
            end
        end else begin
            rd_valid <= 1'b0;
            if (state == IDLE && arm) rd_ptr <= '0;
        end
    end

    assign rd_data = rd_valid ? ram_q : '0;
    assign rd_last = rd_valid && (rd_ptr == PTR_LAST);

endmodule

// File: doc/tdc_trace_recorder.md
# tdc_trace_recorder

Downstream consumer of the TDC sensor's `clkProp` thermometer word in the `clkSample` domain. Encodes each sample to a propagation-depth code, sums 2^g_AVG_LOG2 consecutive codes per trace entry, and records g_DEPTH entries into on-chip RAM after an armed trigger edge. The recorded trace is drained over a valid/ready stream for the host/UART path, replacing ILA-only capture.

## Interface
Parameters:
- `g_LEN`, 32, TDC thermometer width.
- `g_DEPTH`, 256, trace entries per capture; power of two, ≥2.
- `g_AVG_LOG2`, 2, log2 of samples summed per entry; 0 allowed.

Derived widths: `CW = $clog2(g_LEN+1)` (code width); `W = CW + g_AVG_LOG2` (entry width).

Ports:
- `clkSample` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `clkProp` in g_LEN: TDC thermometer sample, bit 0 = shallowest tap.
- `trig` in 1: asynchronous level, e.g. debounced button or activity trigger.
- `arm` in 1: single-cycle arm request.
- `busy` out 1: high in ARMED or CAPTURE.
- `done` out 1: high in READOUT.
- `rd_valid` out 1: entry available.
- `rd_ready` in 1: consumer accepts.
- `rd_data` out W: entry sum.
- `rd_last` out 1: qualifies the final entry.

## Operation
- Input pipeline:
  - S0 registers `clkProp` every cycle.
  - S1 registers the encoded code (CW bits).
- `trig` path: 2-flop synchronizer, then rising-edge detector. `trig_rise` is a one-cycle pulse.
- FSM states: IDLE, ARMED, CAPTURE, READOUT.
  - IDLE → ARMED on `arm`.
  - ARMED → CAPTURE on `trig_rise`.
  - CAPTURE → READOUT after entry g_DEPTH-1 is written.
  - READOUT → IDLE when the handshake completes with `rd_last` high.
- `arm` outside IDLE is ignored.
- `trig_rise` outside ARMED is ignored.
- CAPTURE:
  - Accumulator (W bits) loads the first code of each group, then adds the remaining 2^g_AVG_LOG2 − 1 codes.
  - Completed sum is written to RAM at `wr_ptr`, then `wr_ptr` increments.
  - No overflow is possible: maximum sum is g_LEN·2^g_AVG_LOG2.
- READOUT:
  - `rd_ptr` runs 0..g_DEPTH-1.
  - `rd_data`/`rd_last` are held stable while `rd_valid && !rd_ready`.
  - `rd_valid` does not drop until accepted.
  - `rd_last` is high only with entry g_DEPTH-1.
  - `rd_ptr` advances on `rd_valid && rd_ready`.
- RAM: single-clock simple dual-port, synchronous read. Implementation prefetches so back-to-back acceptance gives one entry per cycle.
- Reset, at any time including mid-capture or mid-readout:
  - State → IDLE; pointers, accumulator and group counter → 0.
  - Synchronizer flops → 0.
  - All outputs → 0.
  - RAM contents are not cleared.

## Timing
- Let `trig_rise` be high in cycle k. The first sample summed is the S1 code present in cycle k+1, i.e. `clkProp` sampled at the edge ending cycle k−1.
- Entry j sums the S1 codes of cycles k+1+j·2^A … k+(j+1)·2^A, with A = g_AVG_LOG2.
- `trig` to `trig_rise`: 3 edges after `trig` rises, with setup met.
- Entering READOUT: the last RAM write occurs in cycle k+g_DEPTH·2^A (the state change cycle).
- `rd_valid` first asserts ≤2 cycles after entering READOUT.
- Throughput: 1 entry/cycle with `rd_ready` held high.
- `busy` and `done` are registered state decodes; they change on the cycle after the FSM transition.

## Configuration
- `TDC_BUBBLE_FILTER_EN` undefined: code = popcount of the S0 word (0..g_LEN).
- `TDC_BUBBLE_FILTER_EN` defined: code = count of contiguous ones from bit 0, i.e. the index of the lowest zero, or g_LEN if all ones. Ones above the first zero (bubbles) are rejected.
- Pipeline latency is identical in both builds.

## Test plan
Bench parameters: g_LEN=32, g_DEPTH=8, g_AVG_LOG2=2 (W=8).
- Constant `clkProp`=32'h0000_FFFF, arm, raise trig → 8 entries of 8'd64, `rd_last` on the 8th, then `done`=0 and `busy`=0.
- `clkProp`=32'h0000_FF7F (bubble at bit 7) → entries 8'd60 without macro, 8'd28 with `TDC_BUBBLE_FILTER_EN`.
- `clkProp`=32'hFFFF_FFFF → entries 8'd128; `clkProp`=0 → entries 8'd0 (boundary codes).
- Ramp: S1 code increments by 1 per cycle starting at 0 at cycle k+1 → entry j = 16j+6.
- `rd_ready` toggling 1-0-0-1 → `rd_data` stable while stalled; no entry duplicated or skipped; exactly 8 accepts.
- Error and reset cases:
  - `arm` during CAPTURE, and `trig` pulse in IDLE → no state change.
  - `rst` in CAPTURE cycle k+10 → IDLE, all outputs 0.
  - A subsequent arm+trig yields a correct full trace.
